// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared pipeline types and default frame/buffer geometry
package edge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } responder_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_IMG_W  = 64;
    localparam int DEF_IMG_H  = 64;

endpackage

// File: rtl/stage_responder_if.sv
// rtl/stage_responder_if.sv - source buffer, datapath and destination buffer signals of a stage
interface stage_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) ();
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              dp_valid_in;
    logic [DATA_W-1:0] dp_data_in;
    logic              dp_valid_out;
    logic [DATA_W-1:0] dp_data_out;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_en, rd_addr, dp_valid_in, dp_data_in, wr_en, wr_addr, wr_data,
        input  rd_data, dp_valid_out, dp_data_out
    );

    modport slave (
        input  rd_en, rd_addr, dp_valid_in, dp_data_in, wr_en, wr_addr, wr_data,
        output rd_data, dp_valid_out, dp_data_out
    );
endinterface

// File: rtl/drain_watchdog.sv
// rtl/drain_watchdog.sv - clearable idle counter whose flag fires as it reaches TIMEOUT-1
module drain_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // Flag on the cycle whose increment lands on TIMEOUT-1, so the owner reacts on that same edge.
    assign expired = !clear && (cnt == CNT_W'(TIMEOUT - 2));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(TIMEOUT - 1)) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/stage_responder.sv
// rtl/stage_responder.sv - streams one frame through a stage datapath and reports completion
module stage_responder
    import edge_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stage_enable,
    output logic               stage_done,
    output logic               busy,
    output logic               timeout_err,
    stage_responder_if.master  bus
);
    localparam int N = IMG_W * IMG_H;

    responder_state_t  state, state_next;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W:0]   wr_cnt;
    logic              dp_valid_q;
    logic              rd_en_c, wr_en_c, active;
    logic              last_read, last_write, wd_expired, wd_fire;

    assign active     = (state == READ) || (state == DRAIN);
    assign rd_en_c    = (state == READ) && stage_enable;
    assign wr_en_c    = active && bus.dp_valid_out && (wr_cnt < (ADDR_W+1)'(N));
    assign last_read  = rd_en_c && (rd_cnt == ADDR_W'(N - 1));
    assign last_write = wr_en_c && (wr_cnt == (ADDR_W+1)'(N - 1));

    drain_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state != DRAIN) || bus.dp_valid_out),
        .expired (wd_expired)
    );

    always_comb begin
        state_next = state;
        wd_fire    = 1'b0;
        case (state)
            IDLE:  if (stage_enable) state_next = READ;
            READ: begin
                if (!stage_enable)  state_next = IDLE;
                else if (last_read) state_next = DRAIN;
            end
            DRAIN: begin
                // Abort beats completion; a final write beats the watchdog.
                if (!stage_enable)   state_next = IDLE;
                else if (last_write) state_next = DONE;
                else if (wd_expired) begin
                    state_next = DONE;
                    wd_fire    = 1'b1;
                end
            end
            DONE:  if (!stage_enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            dp_valid_q  <= 1'b0;
            stage_done  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_next;
            stage_done <= (state_next == DONE);
            busy       <= (state_next == READ) || (state_next == DRAIN);
            dp_valid_q <= rd_en_c;
            if (state_next == IDLE) begin
                rd_cnt      <= '0;
                wr_cnt      <= '0;
                timeout_err <= 1'b0;
            end else begin
                if (rd_en_c && !last_read) rd_cnt <= rd_cnt + 1'b1;
                if (wr_en_c)               wr_cnt <= wr_cnt + 1'b1;
                if (wd_fire)               timeout_err <= 1'b1;
            end
        end
    end

    assign bus.rd_en       = rd_en_c;
    assign bus.rd_addr     = rd_cnt;
    assign bus.dp_valid_in = dp_valid_q;
    assign bus.dp_data_in  = dp_valid_q ? bus.rd_data : '0;
    assign bus.wr_en       = wr_en_c;
    assign bus.wr_addr     = wr_cnt[ADDR_W-1:0];
    assign bus.wr_data     = wr_en_c ? bus.dp_data_out : '0;
endmodule

// File: tb/tb_stage_responder.sv
// tb/tb_stage_responder.sv - randomized and directed runs checked against a frame-level model
module tb_stage_responder;
    localparam int IMG_W = 4, IMG_H = 3, N = IMG_W * IMG_H;
    localparam int DATA_W = 8, ADDR_W = 4, TIMEOUT = 8;

    logic clk = 1'b0, reset = 1'b1, stage_enable = 1'b0;
    logic stage_done, busy, timeout_err;

    stage_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    stage_responder #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .stage_enable(stage_enable),
        .stage_done(stage_done), .busy(busy), .timeout_err(timeout_err), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] src [N];
    logic [7:0] dst [N];

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= src[bus.rd_addr];
        if (bus.wr_en) dst[bus.wr_addr] <= bus.wr_data;
    end

    // Datapath emulator: result = pixel ^ A5 after lat cycles, truncated or padded per run.
    int         lat = 2, emit_max = N, extra_cfg = 0;
    int         emitted = 0, extra_left = 0;
    logic [7:0] pv = '0;
    logic [7:0] pd [8];
    logic [7:0] extra_data = '0;

    always_comb begin
        bus.dp_valid_out = (pv[lat-1] && emitted < emit_max) ||
                           (!pv[lat-1] && emitted >= N && extra_left > 0);
        bus.dp_data_out  = pv[lat-1] ? pd[lat-1] : extra_data;
    end

    always @(posedge clk) begin
        pv    <= {pv[6:0], bus.dp_valid_in};
        pd[0] <= bus.dp_data_in ^ 8'hA5;
        for (int i = 7; i > 0; i--) pd[i] <= pd[i-1];
        extra_data <= 8'($urandom);
        if (!stage_enable) begin
            emitted    <= 0;
            extra_left <= extra_cfg;
        end else if (bus.dp_valid_out) begin
            if (pv[lat-1]) emitted <= emitted + 1;
            else           extra_left <= extra_left - 1;
        end
    end

    int n_checks = 0, n_pass = 0;
    int x_done_at = -1, x_writes = -1, x_terr = -1, x_reads = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level model: a run is reads issued, results accepted and time since the last activity.
    int   cyc = 0, m_reads = 0, m_writes = 0, m_start = 0, m_last_ev = 0, m_prev_addr = 0, bad;
    logic m_run = 0, m_done = 0, m_terr = 0, m_dvi = 0, m_dst_chk = 0;
    logic e_rd, e_wr;
    int   rd_before;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_dst_chk) begin
            bad = 0;
            for (int k = 0; k < N; k++)
                if (k < m_writes && dst[k] !== (src[k] ^ 8'hA5)) bad++;
            chk("dst_contents", bad, 0);
            m_dst_chk = 0;
        end
        e_rd = m_run && stage_enable && (m_reads < N);
        e_wr = m_run && bus.dp_valid_out && (m_writes < N);
        chk("rd_en", bus.rd_en, e_rd);
        if (e_rd) chk("rd_addr", bus.rd_addr, m_reads);
        chk("wr_en", bus.wr_en, e_wr);
        if (e_wr) chk("wr_addr", bus.wr_addr, m_writes);
        chk("wr_data", bus.wr_data, e_wr ? bus.dp_data_out : 8'h00);
        chk("dp_valid_in", bus.dp_valid_in, m_dvi);
        chk("dp_data_in", bus.dp_data_in, m_dvi ? src[m_prev_addr] : 8'h00);
        chk("busy", busy, m_run);
        chk("stage_done", stage_done, m_done);
        chk("timeout_err", timeout_err, m_terr);

        rd_before = m_reads;
        if (reset) begin
            m_run = 0; m_done = 0; m_terr = 0; m_reads = 0; m_writes = 0; m_dvi = 0;
        end else begin
            if (m_done) begin
                if (!stage_enable) begin m_done = 0; m_terr = 0; end
            end else if (!m_run) begin
                if (stage_enable) begin
                    m_run = 1; m_reads = 0; m_writes = 0; m_terr = 0; m_start = cyc;
                end
            end else if (!stage_enable) begin
                m_run = 0;
                if (x_reads >= 0) chk("abort_reads", m_reads, x_reads);
            end else begin
                if (e_rd) begin
                    m_reads++;
                    if (m_reads == N) m_last_ev = cyc;
                end
                if (bus.dp_valid_out) m_last_ev = cyc;
                if (e_wr) m_writes++;
                if ((e_wr && m_writes == N) ||
                    (m_reads == N && cyc - m_last_ev == TIMEOUT - 1)) begin
                    m_terr = !(e_wr && m_writes == N);
                    m_run = 0; m_done = 1; m_dst_chk = 1;
                    if (x_done_at >= 0) chk("done_cycle", cyc + 1 - m_start, x_done_at);
                    if (x_writes >= 0)  chk("done_writes", m_writes, x_writes);
                    if (x_terr >= 0)    chk("done_terr", m_terr, x_terr);
                end
            end
            m_dvi = e_rd;
            m_prev_addr = rd_before;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic new_frame();
        for (int k = 0; k < N; k++) src[k] = 8'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!stage_done && t < 200) begin step(1); t++; end
        if (!stage_done) begin
            $display("FAIL wait_done: stage_done still 0 after %0d cycles", t);
            $fatal(1);
        end
    endtask

    task automatic full_run(input int done_at, input int writes, input int terr, input int hold);
        x_done_at = done_at; x_writes = writes; x_terr = terr; x_reads = -1;
        new_frame();
        stage_enable = 1'b1;
        wait_done();
        step(hold);
        stage_enable = 1'b0;
        step(8);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) pd[k] = '0;
        new_frame();
        step(3);
        reset = 1'b0;
        step(2);

        lat = 2; emit_max = N; extra_cfg = 0;
        full_run(16, 12, 0, 5);

        emit_max = 10;
        full_run(21, 10, 1, 1);

        emit_max = N;
        x_done_at = -1; x_writes = -1; x_terr = -1; x_reads = 5;
        new_frame();
        stage_enable = 1'b1;
        step(6);
        stage_enable = 1'b0;
        step(8);
        full_run(16, 12, 0, 1);

        new_frame();
        x_done_at = -1; x_writes = -1; x_terr = -1; x_reads = -1;
        stage_enable = 1'b1;
        step(14);
        reset = 1'b1; stage_enable = 1'b0;
        step(1);
        reset = 1'b0;
        step(8);

        extra_cfg = 2;
        full_run(16, 12, 0, 4);

        for (int r = 0; r < 25; r++) begin
            int abort_at;
            lat       = $urandom_range(1, 4);
            emit_max  = ($urandom_range(0, 3) == 0) ? $urandom_range(6, N - 1) : N;
            extra_cfg = $urandom_range(0, 2);
            abort_at  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            if (abort_at != 0) begin
                x_done_at = -1; x_writes = -1; x_terr = -1; x_reads = -1;
                new_frame();
                stage_enable = 1'b1;
                step(abort_at);
                stage_enable = 1'b0;
                step($urandom_range(6, 10));
            end else begin
                full_run(-1, -1, -1, $urandom_range(0, 3));
            end
        end

        step(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule
